// File: rtl/mem_stage_if.sv
// EX -> MEM handshake and payload bundle. EX drives the instruction
// and its valid flag; MEM answers with allow_in.
interface mem_stage_if;
  logic        to_mem_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_alu_result;
  logic [2:0]  ex_load_op;
  logic [3:0]  ex_csr_we;
  logic [13:0] ex_csr_num;
  logic [31:0] ex_csr_wdata;
  logic [31:0] ex_csr_wmask;
  logic        ex_ertn;
  logic        ex_syscall;
  logic        mem_allow_in;

  // EX stage side
  modport master (
    output to_mem_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_alu_result,
           ex_load_op, ex_csr_we, ex_csr_num, ex_csr_wdata, ex_csr_wmask,
           ex_ertn, ex_syscall,
    input  mem_allow_in
  );

  // MEM stage side
  modport slave (
    input  to_mem_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_alu_result,
           ex_load_op, ex_csr_we, ex_csr_num, ex_csr_wdata, ex_csr_wmask,
           ex_ertn, ex_syscall,
    output mem_allow_in
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage LoongArch pipeline.
// Holds the EX result, waits for the variable-latency data-SRAM load
// response, aligns/extends load data and hands the writeback, CSR and
// exception bundle to WB over a valid/allow_in handshake. A flushed
// load whose response is still outstanding is drained before new work
// is accepted, so a stale response is never mistaken for a new one.
module mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,          // asynchronous, active-low
  mem_stage_if.slave        ex,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              wb_allow_in,
  input  logic              wb_flush,
  output logic              mem_valid,
  output logic              mem_to_wb_valid,
  output logic [31:0]       mem_pc,
  output logic [3:0]        mem_rf_we,
  output logic [4:0]        mem_rf_waddr,
  output logic [DATA_W-1:0] mem_rf_wdata,
  output logic [3:0]        mem_csr_we,
  output logic [13:0]       mem_csr_num,
  output logic [31:0]       mem_csr_wdata,
  output logic [31:0]       mem_csr_wmask,
  output logic              mem_ertn,
  output logic              mem_syscall,
  output logic              mem_fwd_we,
  output logic [4:0]        mem_fwd_waddr,
  output logic [DATA_W-1:0] mem_fwd_wdata,
  output logic              mem_load_pending
);

  // Load-response tracking states
  localparam logic [1:0] S_IDLE  = 2'd0;  // no load waiting
  localparam logic [1:0] S_WAIT  = 2'd1;  // load held, response not seen
  localparam logic [1:0] S_HOLD  = 2'd2;  // response parked, WB stalled
  localparam logic [1:0] S_DRAIN = 2'd3;  // flushed load still outstanding

  // Load operation encodings
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_B    = 3'b001;
  localparam logic [2:0] LD_H    = 3'b010;
  localparam logic [2:0] LD_W    = 3'b011;
  localparam logic [2:0] LD_BU   = 3'b100;
  localparam logic [2:0] LD_HU   = 3'b101;

  // Pipeline payload registers
  logic [31:0]       pc_q;
  logic [3:0]        rf_we_q;
  logic [4:0]        rf_waddr_q;
  logic [DATA_W-1:0] alu_q;
  logic [2:0]        load_op_q;
  logic [3:0]        csr_we_q;
  logic [13:0]       csr_num_q;
  logic [31:0]       csr_wdata_q;
  logic [31:0]       csr_wmask_q;
  logic              ertn_q;
  logic              syscall_q;

  // Control state
  logic              valid_q, valid_d;
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  // Datapath / handshake intermediates
  logic              is_load;
  logic              ready_go;
  logic              allow_in;
  logic              accept;
  logic              load_cap;
  logic [DATA_W-1:0] ld_src;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_value;
  logic [DATA_W-1:0] rf_wdata;

  assign is_load = (load_op_q != LD_NONE);

  // Stage can advance: non-loads always, loads once their data is here
  always_comb begin
    ready_go = 1'b1;
    if (is_load) begin
      ready_go = ((state_q == S_WAIT) && data_sram_data_ok) || (state_q == S_HOLD);
    end
  end

  // Accept from EX when empty or emptying, never while draining a stale load
  assign allow_in        = (!valid_q || (ready_go && wb_allow_in)) && (state_q != S_DRAIN);
  assign ex.mem_allow_in = allow_in;
  assign accept          = allow_in && ex.to_mem_valid;
  assign load_cap        = accept && !wb_flush && (ex.ex_load_op != LD_NONE);

  // Valid bit: flush wins over capture, otherwise refill when allowed
  always_comb begin
    valid_d = valid_q;
    if (wb_flush) begin
      valid_d = 1'b0;
    end else if (allow_in) begin
      valid_d = ex.to_mem_valid;
    end
  end

  // Response FSM; a response seen while capturing belongs to the older load
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_cap) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wb_flush) begin
          state_d = data_sram_data_ok ? S_IDLE : S_DRAIN;
        end else if (data_sram_data_ok) begin
          if (wb_allow_in) begin
            state_d = load_cap ? S_WAIT : S_IDLE;
          end else begin
            state_d = S_HOLD;
            hold_d  = data_sram_rdata;
          end
        end
      end
      S_HOLD: begin
        if (wb_flush) begin
          state_d = S_IDLE;
        end else if (wb_allow_in) begin
          state_d = load_cap ? S_WAIT : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (data_sram_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset) begin
      valid_q <= 1'b0;
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Payload registers load whenever EX hands over an instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      rf_we_q     <= '0;
      rf_waddr_q  <= '0;
      alu_q       <= '0;
      load_op_q   <= LD_NONE;
      csr_we_q    <= '0;
      csr_num_q   <= '0;
      csr_wdata_q <= '0;
      csr_wmask_q <= '0;
      ertn_q      <= 1'b0;
      syscall_q   <= 1'b0;
    end else if (accept) begin
      pc_q        <= ex.ex_pc;
      rf_we_q     <= ex.ex_rf_we;
      rf_waddr_q  <= ex.ex_rf_waddr;
      alu_q       <= ex.ex_alu_result;
      load_op_q   <= ex.ex_load_op;
      csr_we_q    <= ex.ex_csr_we;
      csr_num_q   <= ex.ex_csr_num;
      csr_wdata_q <= ex.ex_csr_wdata;
      csr_wmask_q <= ex.ex_csr_wmask;
      ertn_q      <= ex.ex_ertn;
      syscall_q   <= ex.ex_syscall;
    end
  end

  // Load data source: live SRAM bus, or the parked copy while WB stalls
  assign ld_src  = (state_q == S_HOLD) ? hold_q : data_sram_rdata;
  assign ld_half = alu_q[1] ? ld_src[31:16] : ld_src[15:0];

  // Byte lane selected by the low address bits
  always_comb begin
    ld_byte = ld_src[7:0];
    case (alu_q[1:0])
      2'd0:    ld_byte = ld_src[7:0];
      2'd1:    ld_byte = ld_src[15:8];
      2'd2:    ld_byte = ld_src[23:16];
      default: ld_byte = ld_src[31:24];
    endcase
  end

  // Sign/zero extension per load type
  always_comb begin
    ld_value = '0;
    case (load_op_q)
      LD_B:    ld_value = {{24{ld_byte[7]}}, ld_byte};
      LD_H:    ld_value = {{16{ld_half[15]}}, ld_half};
      LD_W:    ld_value = ld_src;
      LD_BU:   ld_value = {24'b0, ld_byte};
      LD_HU:   ld_value = {16'b0, ld_half};
      default: ld_value = '0;
    endcase
  end

  assign rf_wdata = is_load ? ld_value : alu_q;

  // Handshake toward WB
  assign mem_valid       = valid_q;
  assign mem_to_wb_valid = valid_q && ready_go && !wb_flush;

  // Writeback / CSR / exception bundle, enables gated by valid
  assign mem_pc        = pc_q;
  assign mem_rf_we     = valid_q ? rf_we_q : 4'b0;
  assign mem_rf_waddr  = rf_waddr_q;
  assign mem_rf_wdata  = rf_wdata;
  assign mem_csr_we    = valid_q ? csr_we_q : 4'b0;
  assign mem_csr_num   = csr_num_q;
  assign mem_csr_wdata = csr_wdata_q;
  assign mem_csr_wmask = csr_wmask_q;
  assign mem_ertn      = valid_q && ertn_q;
  assign mem_syscall   = valid_q && syscall_q;

  // Bypass and load-use hazard information for ID
  assign mem_fwd_we       = valid_q && (|rf_we_q) && ready_go;
  assign mem_fwd_waddr    = rf_waddr_q;
  assign mem_fwd_wdata    = rf_wdata;
  assign mem_load_pending = valid_q && is_load && !ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by a
// randomized run, all compared against a transaction-level model of the
// stage (one instruction slot, a "data received" flag, a drain flag).
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  rf_we;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [2:0]  op;
    logic [3:0]  csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;
    logic        ertn;
    logic        sys;
  } inst_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_ok;
  logic [31:0] rdata;
  logic        wb_allow;
  logic        wb_flush;

  logic        mem_valid, mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [3:0]  mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic [31:0] mem_rf_wdata;
  logic [3:0]  mem_csr_we;
  logic [13:0] mem_csr_num;
  logic [31:0] mem_csr_wdata, mem_csr_wmask;
  logic        mem_ertn, mem_syscall;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_waddr;
  logic [31:0] mem_fwd_wdata;
  logic        mem_load_pending;

  mem_stage_if ex_if ();

  mem_stage #(.DATA_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .ex                (ex_if.slave),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .wb_allow_in       (wb_allow),
    .wb_flush          (wb_flush),
    .mem_valid         (mem_valid),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_pc            (mem_pc),
    .mem_rf_we         (mem_rf_we),
    .mem_rf_waddr      (mem_rf_waddr),
    .mem_rf_wdata      (mem_rf_wdata),
    .mem_csr_we        (mem_csr_we),
    .mem_csr_num       (mem_csr_num),
    .mem_csr_wdata     (mem_csr_wdata),
    .mem_csr_wmask     (mem_csr_wmask),
    .mem_ertn          (mem_ertn),
    .mem_syscall       (mem_syscall),
    .mem_fwd_we        (mem_fwd_we),
    .mem_fwd_waddr     (mem_fwd_waddr),
    .mem_fwd_wdata     (mem_fwd_wdata),
    .mem_load_pending  (mem_load_pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference: value a load of type op at address offset a returns from word w
  function automatic logic [31:0] load_value(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = a[1] ? (w >> 16) : (w & 32'hFFFF);
    case (op)
      3'd1:    return (b >= 32'd128)   ? (b + 32'hFFFF_FF00) : b;
      3'd2:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
      3'd3:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  // Model state: the instruction slot and its load progress
  inst_t       ex_cur;
  inst_t       m_inst;
  logic        m_valid, m_got, m_drain;
  logic [31:0] m_data;
  logic        accepted, entered;

  task automatic model_reset();
    m_valid = 1'b0; m_got = 1'b0; m_drain = 1'b0; m_data = '0;
    m_inst = '0; accepted = 1'b0; entered = 1'b0;
  endtask

  task automatic drive_ex(input logic v, input inst_t i);
    ex_cur                  = i;
    ex_if.to_mem_valid      = v;
    ex_if.ex_pc             = i.pc;
    ex_if.ex_rf_we          = i.rf_we;
    ex_if.ex_rf_waddr       = i.waddr;
    ex_if.ex_alu_result     = i.alu;
    ex_if.ex_load_op        = i.op;
    ex_if.ex_csr_we         = i.csr_we;
    ex_if.ex_csr_num        = i.csr_num;
    ex_if.ex_csr_wdata      = i.csr_wdata;
    ex_if.ex_csr_wmask      = i.csr_wmask;
    ex_if.ex_ertn           = i.ertn;
    ex_if.ex_syscall        = i.sys;
  endtask

  function automatic inst_t mk_inst(input logic [2:0] op, input logic [31:0] alu,
                                    input logic [3:0] we, input logic [4:0] waddr);
    inst_t i;
    i = '0;
    i.pc = 32'h1C00_0000 + alu; i.op = op; i.alu = alu; i.rf_we = we; i.waddr = waddr;
    i.csr_num = 14'h5; i.csr_wdata = 32'hA5A5_0000 ^ alu; i.csr_wmask = 32'hFFFF_0000;
    return i;
  endfunction

  function automatic inst_t rand_inst();
    inst_t i;
    i.pc = $urandom; i.rf_we = 4'($urandom); i.waddr = 5'($urandom); i.alu = $urandom;
    i.op = ($urandom % 2 == 0) ? 3'd0 : 3'($urandom_range(1, 5));
    i.csr_we = 4'($urandom); i.csr_num = 14'($urandom);
    i.csr_wdata = $urandom; i.csr_wmask = $urandom;
    i.ertn = ($urandom % 8 == 0); i.sys = ($urandom % 8 == 0);
    return i;
  endfunction

  task automatic idle_inputs();
    drive_ex(1'b0, '0);
    data_ok = 1'b0; rdata = $urandom; wb_allow = 1'b1; wb_flush = 1'b0;
  endtask

  // One clock cycle: inputs are already driven; compare at the falling edge,
  // advance the model to what the next rising edge does, return just after it.
  task automatic tick();
    logic        is_ld, ready, exp_allow, exp_wb;
    logic [31:0] word, exp_wd;
    @(negedge clk);
    is_ld     = (m_inst.op != 3'd0);
    ready     = !is_ld || m_got || data_ok;
    exp_allow = (!m_valid || (ready && wb_allow)) && !m_drain;
    exp_wb    = m_valid && ready && !wb_flush;
    word      = m_got ? m_data : rdata;
    exp_wd    = is_ld ? load_value(m_inst.op, m_inst.alu[1:0], word) : m_inst.alu;

    check("allow_in",  64'(ex_if.mem_allow_in), 64'(exp_allow));
    check("mem_valid", 64'(mem_valid), 64'(m_valid));
    check("to_wb",     64'(mem_to_wb_valid), 64'(exp_wb));
    check("pending",   64'(mem_load_pending), 64'(m_valid && is_ld && !ready));
    check("fwd_we",    64'(mem_fwd_we), 64'(m_valid && (|m_inst.rf_we) && ready));
    check("rf_we",     64'(mem_rf_we), 64'(m_valid ? m_inst.rf_we : 4'h0));
    check("csr_we",    64'(mem_csr_we), 64'(m_valid ? m_inst.csr_we : 4'h0));
    check("flags",     64'({mem_ertn, mem_syscall}),
          64'(m_valid ? {m_inst.ertn, m_inst.sys} : 2'b00));
    if (m_valid && ready) begin
      check("rf_wdata", 64'(mem_rf_wdata), 64'(exp_wd));
      check("fwd_data", 64'({mem_fwd_waddr, mem_fwd_wdata}), 64'({m_inst.waddr, exp_wd}));
    end
    if (m_valid) begin
      check("pc_waddr", 64'({mem_pc, mem_rf_waddr}), 64'({m_inst.pc, m_inst.waddr}));
      check("csr",      64'({mem_csr_num, mem_csr_wdata}), 64'({m_inst.csr_num, m_inst.csr_wdata}));
      check("csr_mask", 64'(mem_csr_wmask), 64'(m_inst.csr_wmask));
    end

    // Next state of the model
    if (data_ok) begin
      if (m_drain) m_drain = 1'b0;
      else if (m_valid && is_ld && !m_got) begin m_got = 1'b1; m_data = rdata; end
    end
    if (exp_wb && wb_allow) m_valid = 1'b0;
    if (wb_flush) begin
      if (m_valid && is_ld && !m_got && !data_ok) m_drain = 1'b1;
      m_valid = 1'b0;
    end
    accepted = exp_allow && ex_if.to_mem_valid;
    entered  = accepted && !wb_flush && (ex_cur.op != 3'd0);
    if (exp_allow) begin
      m_valid = ex_if.to_mem_valid && !wb_flush;
      if (ex_if.to_mem_valid) begin m_inst = ex_cur; m_got = 1'b0; end
    end
    @(posedge clk);
    #1;
  endtask

  // Capture a load, answer it after 'delay' cycles with 'word', check result
  task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] alu,
                          input logic [31:0] word, input int delay, input logic [31:0] exp);
    idle_inputs();
    drive_ex(1'b1, mk_inst(op, alu, 4'hF, 5'd9));
    tick();
    for (int i = 1; i <= delay; i++) begin
      idle_inputs();
      data_ok = (i == delay);
      rdata   = (i == delay) ? word : 32'hDEAD_BEEF;
      #1;
      if (i < delay) begin
        check({tag, "_pend"},  64'(mem_load_pending), 64'(1));
        check({tag, "_allow"}, 64'(ex_if.mem_allow_in), 64'(0));
      end else begin
        check({tag, "_data"}, 64'(mem_rf_wdata), 64'(exp));
        check({tag, "_wbv"},  64'(mem_to_wb_valid), 64'(1));
      end
      tick();
    end
  endtask

  int          sr_cnt;
  logic        sr_busy;
  logic [31:0] sr_data;
  logic        ex_pending;
  inst_t       ex_next;

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    // Reset state
    check("rst_allow", 64'(ex_if.mem_allow_in), 64'(1));
    check("rst_ctl",   64'({mem_valid, mem_to_wb_valid, mem_load_pending, mem_fwd_we}), 64'(0));
    check("rst_pc",    64'({mem_pc, mem_rf_we, mem_rf_waddr}), 64'(0));
    check("rst_wdata", 64'({mem_rf_wdata, mem_fwd_wdata}), 64'(0));
    check("rst_csr",   64'({mem_csr_we, mem_csr_num, mem_csr_wdata}), 64'(0));
    check("rst_misc",  64'({mem_csr_wmask, mem_ertn, mem_syscall, mem_fwd_waddr}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Non-load: result available the cycle after capture
    drive_ex(1'b1, mk_inst(3'd0, 32'h1234, 4'hF, 5'd5));
    tick();
    idle_inputs();
    #1;
    check("add_wbv",   64'(mem_to_wb_valid), 64'(1));
    check("add_wdata", 64'(mem_rf_wdata), 64'(32'h1234));
    check("add_fwd",   64'({mem_fwd_we, mem_fwd_waddr}), 64'({1'b1, 5'd5}));
    tick();

    // Loads with alignment and extension
    run_load("ldb",  3'd1, 32'h0000_1002, 32'h0080_FF00, 3, 32'hFFFF_FF80);
    run_load("ldhu", 3'd5, 32'h0000_2002, 32'h8001_5A5A, 1, 32'h0000_8001);
    run_load("ldh",  3'd2, 32'h0000_3000, 32'h0000_FFFE, 2, 32'hFFFF_FFFE);
    run_load("ldbu", 3'd4, 32'h0000_4003, 32'h9F00_0000, 1, 32'h0000_009F);
    run_load("ldw",  3'd3, 32'h0000_5001, 32'h1357_9BDF, 2, 32'h1357_9BDF);

    // Response arrives while WB stalls: value parked, bus garbage ignored
    idle_inputs();
    drive_ex(1'b1, mk_inst(3'd3, 32'h0000_0100, 4'hF, 5'd7));
    tick();
    idle_inputs(); data_ok = 1'b1; rdata = 32'hCAFE_F00D; wb_allow = 1'b0;
    tick();
    idle_inputs(); rdata = 32'h0BAD_0BAD; wb_allow = 1'b0;
    #1;
    check("hold_wbv",  64'(mem_to_wb_valid), 64'(1));
    check("hold_data", 64'(mem_rf_wdata), 64'(32'hCAFE_F00D));
    tick();
    idle_inputs(); rdata = 32'h5555_AAAA;
    #1;
    check("hold_rel",  64'(mem_rf_wdata), 64'(32'hCAFE_F00D));
    tick();

    // Flush while waiting: drain the stale response before accepting work
    idle_inputs();
    drive_ex(1'b1, mk_inst(3'd3, 32'h0000_0200, 4'hF, 5'd8));
    tick();
    idle_inputs(); wb_flush = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("drain_valid", 64'(mem_valid), 64'(0));
    check("drain_allow", 64'(ex_if.mem_allow_in), 64'(0));
    tick();
    idle_inputs(); data_ok = 1'b1; rdata = 32'h7777_7777;
    #1;
    check("drain_ok_allow", 64'(ex_if.mem_allow_in), 64'(0));
    check("drain_ok_wbv",   64'(mem_to_wb_valid), 64'(0));
    tick();
    idle_inputs();
    drive_ex(1'b1, mk_inst(3'd0, 32'h0000_0ABC, 4'h1, 5'd3));
    #1;
    check("post_drain_allow", 64'(ex_if.mem_allow_in), 64'(1));
    tick();
    idle_inputs();
    #1;
    check("post_drain_wb", 64'({mem_to_wb_valid, mem_rf_wdata}), 64'({1'b1, 32'h0ABC}));
    tick();

    // Asynchronous reset in the middle of a load wait
    idle_inputs();
    drive_ex(1'b1, mk_inst(3'd1, 32'h0000_0300, 4'hF, 5'd4));
    tick();
    idle_inputs();
    #1;
    check("ares_pending", 64'(mem_load_pending), 64'(1));
    #1;
    reset = 1'b0;
    #1;
    check("ares_ctl",   64'({mem_valid, mem_to_wb_valid, mem_load_pending, mem_fwd_we}), 64'(0));
    check("ares_data",  64'({mem_pc, mem_rf_wdata}), 64'(0));
    check("ares_we",    64'({mem_rf_we, mem_csr_we, mem_ertn, mem_syscall}), 64'(0));
    check("ares_allow", 64'(ex_if.mem_allow_in), 64'(1));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ares_rel_allow", 64'(ex_if.mem_allow_in), 64'(1));

    // Randomized traffic against the model
    sr_busy = 1'b0; sr_cnt = 0; sr_data = '0; ex_pending = 1'b0; ex_next = '0;
    for (int c = 0; c < 4000; c++) begin
      if (!ex_pending && ($urandom % 5 != 0)) begin
        ex_next = rand_inst();
        ex_pending = 1'b1;
      end
      drive_ex(ex_pending, ex_next);
      if (sr_busy && sr_cnt == 1) begin
        data_ok = 1'b1; rdata = sr_data; sr_busy = 1'b0;
      end else begin
        data_ok = 1'b0; rdata = $urandom;
        if (sr_busy) sr_cnt--;
      end
      wb_allow = ($urandom % 4 != 0);
      wb_flush = ($urandom % 12 == 0);
      tick();
      if (accepted) ex_pending = 1'b0;
      if (entered) begin
        sr_busy = 1'b1; sr_cnt = $urandom_range(1, 4); sr_data = $urandom;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the five-stage LoongArch pipeline. It sits between EX and WB_stage.
- Latches the EX result and waits for a variable-latency data-SRAM load response.
- Byte/half-aligns and extends load data, then hands a complete writeback/CSR/exception bundle to WB using the valid/allow_in handshake.
- Provides bypass and load-use hazard information to ID, and discards in-flight responses when WB flushes.

Parameters:
DATA_W, 32, datapath width; only 32 supported.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
to_mem_valid  in  1  EX holds a valid instruction for MEM
ex_pc  in  32  instruction PC
ex_rf_we  in  4  regfile write enables
ex_rf_waddr  in  5  destination register
ex_alu_result  in  32  ALU result / load address
ex_load_op  in  3  000 none, 001 ld.b, 010 ld.h, 011 ld.w, 100 ld.bu, 101 ld.hu
ex_csr_we  in  4  CSR write enables
ex_csr_num  in  14  CSR number
ex_csr_wdata  in  32  CSR write data
ex_csr_wmask  in  32  CSR write mask
ex_ertn  in  1  ertn instruction
ex_syscall  in  1  syscall instruction
data_sram_data_ok  in  1  load response valid, one pulse per issued load
data_sram_rdata  in  32  load response data
wb_allow_in  in  1  WB can accept
wb_flush  in  1  WB exception or ertn commit; kill MEM contents
mem_allow_in  out  1  MEM can accept from EX
mem_valid  out  1  MEM holds a live instruction
mem_to_wb_valid  out  1  bundle valid toward WB
mem_pc  out  32  forwarded PC
mem_rf_we / mem_rf_waddr / mem_rf_wdata  out  4/5/32  writeback bundle
mem_csr_we / mem_csr_num / mem_csr_wdata / mem_csr_wmask  out  4/14/32/32  CSR bundle
mem_ertn / mem_syscall  out  1/1  exception flags
mem_fwd_we / mem_fwd_waddr / mem_fwd_wdata  out  1/5/32  bypass to ID
mem_load_pending  out  1  load in MEM without data yet (ID must stall)

Behaviour:
- Reset (async, reset=0):
  - All pipeline registers are 0; FSM goes to IDLE; mem_valid=0.
  - Every output is 0, except mem_allow_in=1.
- Capture:
  - On a clk edge with mem_allow_in=1, mem_valid <= to_mem_valid && !wb_flush.
  - The payload registers load from the ex_* inputs when to_mem_valid=1.
- FSM states:
  - IDLE: no load waiting.
  - WAIT: load held, response not yet seen.
  - HOLD: response captured in a 32-bit holding register, waiting for WB.
  - DRAIN: flushed load still outstanding.
- Transitions:
  - A load is captured → WAIT. If data_ok is already high that cycle, it belongs to an earlier request; only DRAIN consumes it.
  - WAIT & data_ok & wb_allow_in → IDLE, or → WAIT if a new load is captured the same edge.
  - WAIT & data_ok & !wb_allow_in → HOLD; the holding register latches rdata.
  - HOLD & wb_allow_in → IDLE, or → WAIT on a new load.
  - WAIT & wb_flush & !data_ok → DRAIN.
  - WAIT & wb_flush & data_ok → IDLE; the response is discarded.
  - DRAIN & data_ok → IDLE.
- ready_go:
  - 1 for non-loads, for WAIT & data_ok, and for HOLD.
  - 0 otherwise.
- Handshake signals:
  - mem_allow_in = (!mem_valid || (ready_go && wb_allow_in)) && state!=DRAIN.
  - mem_to_wb_valid = mem_valid && ready_go && !wb_flush.
- Flush: wb_flush clears mem_valid at the next edge and overrides capture. mem_valid=0 throughout DRAIN.
- Load data:
  - Source is data_sram_rdata in WAIT, or the holding register in HOLD.
  - a = ex_alu_result[1:0] (registered); byte = src[8a+7:8a]; half = a[1] ? src[31:16] : src[15:0].
  - ld.b / ld.h sign-extend; ld.bu / ld.hu zero-extend; ld.w passes the word; a is ignored for ld.w.
- mem_rf_wdata is the load value for loads, else the registered alu_result.
- Valid gating:
  - mem_rf_we = mem_valid ? rf_we : 0.
  - mem_csr_we = mem_valid ? csr_we : 0.
  - mem_ertn and mem_syscall are gated the same way.
- Bypass:
  - mem_fwd_we = mem_valid && |rf_we && ready_go; mem_fwd_wdata = mem_rf_wdata.
  - mem_load_pending = mem_valid && load && !ready_go.
- Reset mid-load: FSM returns to IDLE immediately; late responses after reset are the SRAM's concern.

Test Plan:
- Non-load: add with alu_result=0x1234, rf_we=0xF, waddr=5 → mem_to_wb_valid 1 the cycle after capture; mem_rf_wdata=0x1234; mem_fwd_we=1.
- ld.b, addr low bits=2, rdata=0x0080FF00, data_ok 3 cycles after capture:
  - mem_load_pending=1 and mem_allow_in=0 for 2 cycles.
  - Then wdata=0xFFFFFF80 with mem_to_wb_valid=1.
- ld.hu at a=2, rdata=0x8001xxxx → 0x00008001; ld.h at a=0, rdata=0x0000FFFE → 0xFFFFFFFE.
- Load response with wb_allow_in=0 for 2 cycles → state HOLD; rdata changes to garbage; WB later receives the original value.
- wb_flush while in WAIT, data_ok 2 cycles later:
  - mem_valid=0; mem_allow_in=0 until data_ok.
  - No WB valid issued; next instruction is accepted the cycle after data_ok.
- Assert reset=0 asynchronously mid-WAIT → all outputs 0 without a clock edge; mem_allow_in=1 after release.
